// File: rtl/irda_mir_tx_sequencer.sv
// irda_mir_tx_sequencer: frame-level sequencer for the MIR transmit path.
// A frame is: restart the data controller, send PREAMBLE_FLAGS x 0x7E, send the
// zero-stuffed data bits, send the zero-stuffed inverted CRC-16 LSB first, and
// finish with one 0x7E stop flag. One bit leaves per bit_tick_i strobe.
// Optional HDLC abort (input abort_i) is compiled in with `define IRDA_MIR_ABORT_EN.
//
// Data handshake: data_available_i qualifies data_bit_i. next_data_o is a
// single-cycle strobe meaning "data_bit_i was consumed on this edge"; the data
// controller presents the next bit, or drops data_available_i, by the next cycle.
module irda_mir_tx_sequencer #(
    parameter int unsigned PREAMBLE_FLAGS = 2,
    parameter logic [15:0] CRC_INIT       = 16'hFFFF
) (
    input  logic clk,
    input  logic wb_rst_n,
    input  logic tx_start_i,
    input  logic bit_tick_i,
    input  logic data_bit_i,
    input  logic data_available_i,
`ifdef IRDA_MIR_ABORT_EN
    input  logic abort_i,
`endif
    output logic dc_restart_o,
    output logic next_data_o,
    output logic mir_tx_enabled_o,
    output logic tx_bit_o,
    output logic tx_busy_o,
    output logic tx_done_o
);

    typedef enum logic [3:0] {
        S_IDLE, S_RESTART, S_WAIT_DATA, S_FLAG, S_DATA, S_CRC, S_STOP, S_DONE, S_ABORT
    } state_t;

    localparam logic [7:0]  FLAG_BYTE = 8'h7E;
    localparam logic [6:0]  FLAG_LAST = 7'(PREAMBLE_FLAGS * 8 - 1);
    localparam logic [15:0] CRC_POLY  = 16'h8408;  // 0x1021 bit-reversed for LSB-first

    state_t      state_q, state_d;
    logic        tx_bit_q, tx_bit_d;
    logic [15:0] crc_q, crc_d;
    logic [2:0]  stuff_q, stuff_d;
    logic [6:0]  cnt_q, cnt_d;
    logic        aborted_q, aborted_d;

    logic        abort_req;
    logic        stuff_now;
    logic [15:0] crc_next;
    logic        crc_out;

`ifdef IRDA_MIR_ABORT_EN
    assign abort_req = abort_i && (state_q == S_FLAG || state_q == S_DATA || state_q == S_CRC);
`else
    assign abort_req = 1'b0;
`endif

    // Five consecutive ones have gone out: the next tick must carry a stuffed zero.
    assign stuff_now = (stuff_q == 3'd5);
    assign crc_next  = {1'b0, crc_q[15:1]} ^ ((crc_q[0] ^ data_bit_i) ? CRC_POLY : 16'h0000);
    // DATA's exit tick always sends CRC bit 0; CRC state indexes by cnt_q.
    assign crc_out   = (state_q == S_DATA) ? ~crc_q[0] : ~crc_q[cnt_q[3:0]];

    // State register.
    always_ff @(posedge clk or negedge wb_rst_n) begin
        if (!wb_rst_n) state_q <= S_IDLE;
        else           state_q <= state_d;
    end

    // Next-state logic; a tick only counts once the state has been entered.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:      if (tx_start_i) state_d = S_RESTART;
            S_RESTART:   state_d = S_WAIT_DATA;
            S_WAIT_DATA: if (data_available_i) state_d = S_FLAG;
            S_FLAG: begin
                if (abort_req) state_d = S_ABORT;
                else if (bit_tick_i && cnt_q == FLAG_LAST) state_d = S_DATA;
            end
            S_DATA: begin
                if (abort_req) state_d = S_ABORT;
                else if (bit_tick_i && !stuff_now && !data_available_i) state_d = S_CRC;
            end
            S_CRC: begin
                if (abort_req) state_d = S_ABORT;
                else if (bit_tick_i && !stuff_now && cnt_q == 7'd15) state_d = S_STOP;
            end
            S_STOP:      if (bit_tick_i && cnt_q == 7'd7) state_d = S_DONE;
            S_ABORT:     if (bit_tick_i && cnt_q == 7'd7) state_d = S_DONE;
            S_DONE:      state_d = S_IDLE;
            default:     state_d = S_IDLE;
        endcase
    end

    // FSM outputs; next_data_o is combinational so the consume strobe shares the tick cycle.
    always_comb begin
        dc_restart_o     = (state_q == S_RESTART) || (state_q == S_DONE && aborted_q);
        next_data_o      = bit_tick_i && (state_q == S_DATA) && !stuff_now &&
                           data_available_i && !abort_req;
        mir_tx_enabled_o = (state_q == S_DATA);
        tx_busy_o        = (state_q != S_IDLE) && (state_q != S_DONE);
        tx_done_o        = (state_q == S_DONE);
    end

    assign tx_bit_o = tx_bit_q;

    // Datapath next values: serial bit, CRC, stuff counter and bit counter.
    always_comb begin
        tx_bit_d  = tx_bit_q;
        crc_d     = crc_q;
        stuff_d   = stuff_q;
        cnt_d     = cnt_q;
        aborted_d = aborted_q;
        case (state_q)
            S_IDLE: aborted_d = 1'b0;
            S_RESTART: begin
                crc_d     = CRC_INIT;
                stuff_d   = 3'd0;
                cnt_d     = 7'd0;
                aborted_d = 1'b0;
            end
            S_FLAG, S_STOP: begin
                if (abort_req) begin
                    cnt_d = 7'd0;
                end else if (bit_tick_i) begin
                    tx_bit_d = FLAG_BYTE[cnt_q[2:0]];
                    if ((state_q == S_FLAG && cnt_q == FLAG_LAST) ||
                        (state_q == S_STOP && cnt_q == 7'd7)) cnt_d = 7'd0;
                    else                                      cnt_d = cnt_q + 7'd1;
                end
            end
            S_DATA, S_CRC: begin
                if (abort_req) begin
                    cnt_d = 7'd0;
                end else if (bit_tick_i) begin
                    if (stuff_now) begin
                        tx_bit_d = 1'b0;
                        stuff_d  = 3'd0;
                    end else if (state_q == S_DATA && data_available_i) begin
                        tx_bit_d = data_bit_i;
                        crc_d    = crc_next;
                        stuff_d  = data_bit_i ? stuff_q + 3'd1 : 3'd0;
                    end else begin
                        tx_bit_d = crc_out;
                        stuff_d  = crc_out ? stuff_q + 3'd1 : 3'd0;
                        if (state_q == S_DATA)   cnt_d = 7'd1;
                        else if (cnt_q == 7'd15) cnt_d = 7'd0;
                        else                     cnt_d = cnt_q + 7'd1;
                    end
                end
            end
            S_ABORT: begin
                if (bit_tick_i) begin
                    tx_bit_d = 1'b1;
                    if (cnt_q == 7'd7) begin
                        cnt_d     = 7'd0;
                        aborted_d = 1'b1;
                    end else begin
                        cnt_d = cnt_q + 7'd1;
                    end
                end
            end
            S_DONE: tx_bit_d = 1'b0;
            default: tx_bit_d = tx_bit_q;
        endcase
    end

    // Datapath registers.
    always_ff @(posedge clk or negedge wb_rst_n) begin
        if (!wb_rst_n) begin
            tx_bit_q  <= 1'b0;
            crc_q     <= CRC_INIT;
            stuff_q   <= 3'd0;
            cnt_q     <= 7'd0;
            aborted_q <= 1'b0;
        end else begin
            tx_bit_q  <= tx_bit_d;
            crc_q     <= crc_d;
            stuff_q   <= stuff_d;
            cnt_q     <= cnt_d;
            aborted_q <= aborted_d;
        end
    end

endmodule

// File: tb/tb_irda_mir_tx_sequencer.sv
// Bench for irda_mir_tx_sequencer: a small data-controller model feeds 32-bit
// words, the emitted bit stream is recorded per tick and compared with a frame
// built from HDLC rules (flags, stuffing, MSB-first CRC definition reflected).
`timescale 1ns/1ps
module tb_irda_mir_tx_sequencer;
  localparam int P_FLAGS = 2;

  logic clk = 1'b0;
  logic wb_rst_n = 1'b1;
  logic tx_start_i = 1'b0;
  logic bit_tick_i = 1'b0;
  logic data_bit_i = 1'b0;
  logic data_available_i = 1'b0;
  logic abort_i = 1'b0;
  logic dc_restart_o, next_data_o, mir_tx_enabled_o, tx_bit_o, tx_busy_o, tx_done_o;

  always #5 clk = ~clk;

  irda_mir_tx_sequencer #(.PREAMBLE_FLAGS(P_FLAGS), .CRC_INIT(16'hFFFF)) dut (
    .clk(clk),
    .wb_rst_n(wb_rst_n),
    .tx_start_i(tx_start_i),
    .bit_tick_i(bit_tick_i),
    .data_bit_i(data_bit_i),
    .data_available_i(data_available_i),
`ifdef IRDA_MIR_ABORT_EN
    .abort_i(abort_i),
`endif
    .dc_restart_o(dc_restart_o),
    .next_data_o(next_data_o),
    .mir_tx_enabled_o(mir_tx_enabled_o),
    .tx_bit_o(tx_bit_o),
    .tx_busy_o(tx_busy_o),
    .tx_done_o(tx_done_o)
  );

  int n_checks = 0;
  int n_pass = 0;

  // data controller model
  logic [31:0] dc_word;
  int dc_len, dc_ptr;
  bit dc_hold;

  // scoreboard
  logic exp_q[$];
  logic obs_q[$];

  // per-frame observations
  int nd_cnt, nd_hold, rs_cnt, hold_bad;
  logic busy_start, done_seen, done_busy, done_rs, done_after, bit_after, pre_en;
  logic [5:0] rst_outs;

  // ---------------- reference model ----------------
  function automatic logic [15:0] rev16(input logic [15:0] v);
    logic [15:0] r;
    for (int i = 0; i < 16; i++) r[i] = v[15-i];
    return r;
  endfunction

  // Textbook MSB-first CRC-16 (poly 0x1021) on a reflected register; returns
  // the register in LSB-first orientation.
  function automatic logic [15:0] crc_model(input logic [31:0] word);
    logic [15:0] r;
    logic fb;
    r = rev16(16'hFFFF);
    for (int i = 0; i < 32; i++) begin
      fb = r[15] ^ word[i];
      r = {r[14:0], 1'b0};
      if (fb) r = r ^ 16'h1021;
    end
    return rev16(r);
  endfunction

  function automatic void model_frame(input logic [31:0] word);
    logic payload[$];
    logic [7:0] flag_b;
    logic [15:0] fcs;
    int ones;
    flag_b = 8'h7E;
    exp_q.delete();
    for (int f = 0; f < P_FLAGS; f++)
      for (int b = 0; b < 8; b++) exp_q.push_back(flag_b[b]);
    fcs = crc_model(word);
    for (int i = 0; i < 32; i++) payload.push_back(word[i]);
    for (int i = 0; i < 16; i++) payload.push_back(~fcs[i]);
    ones = 0;
    for (int i = 0; i < payload.size(); i++) begin
      exp_q.push_back(payload[i]);
      ones = payload[i] ? ones + 1 : 0;
      if (ones == 5 && i != payload.size() - 1) begin
        exp_q.push_back(1'b0);
        ones = 0;
      end
    end
    for (int b = 0; b < 8; b++) exp_q.push_back(flag_b[b]);
  endfunction

  function automatic int first_diff();
    for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++)
      if (obs_q[i] !== exp_q[i]) return i;
    return -1;
  endfunction

  // ---------------- drivers ----------------
  // Called just after a negedge; returns at the following negedge.
  task automatic drive_cycle(input logic tick, input logic start, input logic abort);
    logic nd_now, rs_now;
    bit_tick_i = tick;
    tx_start_i = start;
    abort_i = abort;
    data_available_i = !dc_hold && (dc_ptr < dc_len);
    data_bit_i = (dc_ptr < dc_len) ? dc_word[dc_ptr[4:0]] : 1'b0;
    #1;
    nd_now = next_data_o;
    rs_now = dc_restart_o;
    if (nd_now) nd_cnt++;
    if (rs_now) rs_cnt++;
    @(posedge clk);
    if (rs_now) dc_ptr = 0;
    else if (nd_now) dc_ptr++;
    @(negedge clk);
    bit_tick_i = 1'b0;
    tx_start_i = 1'b0;
    abort_i = 1'b0;
  endtask

  task automatic run_frame(input logic [31:0] word, input int hold_cycles,
                           input int start_at, input int abort_at, input int reset_at);
    int guard;
    logic tick, st, ab, fired;
    obs_q.delete();
    nd_cnt = 0; nd_hold = 0; rs_cnt = 0; hold_bad = 0;
    done_seen = 0; done_busy = 1; done_rs = 0; done_after = 1; bit_after = 1; fired = 0;
    dc_word = word; dc_len = 32; dc_ptr = 0; dc_hold = 1;
    drive_cycle(1'b0, 1'b1, 1'b0);
    busy_start = tx_busy_o;
    for (int i = 0; i <= hold_cycles; i++) begin
      drive_cycle(1'($urandom_range(0, 1)), 1'b0, 1'b0);
      if (tx_bit_o !== 1'b0) hold_bad++;
    end
    nd_hold = nd_cnt;
    dc_hold = 0;
    drive_cycle(1'($urandom_range(0, 1)), 1'b0, 1'b0);
    if (tx_bit_o !== 1'b0) hold_bad++;
    guard = 0;
    while (!done_seen && guard < 3000) begin
      guard++;
      if (reset_at >= 0 && obs_q.size() >= reset_at) begin
        bit_tick_i = 1'b1;
        #1;
        pre_en = mir_tx_enabled_o;
        wb_rst_n = 1'b0;
        #1;
        rst_outs = {dc_restart_o, next_data_o, mir_tx_enabled_o, tx_bit_o, tx_busy_o, tx_done_o};
        bit_tick_i = 1'b0;
        return;
      end
      tick = 0; st = 0; ab = 0;
      if (!fired && start_at >= 0 && obs_q.size() == start_at) begin
        st = 1; fired = 1;
      end else if (!fired && abort_at >= 0 && obs_q.size() == abort_at) begin
        ab = 1; fired = 1;
      end else begin
        tick = ($urandom_range(0, 2) != 0);
      end
      drive_cycle(tick, st, ab);
      if (tick) obs_q.push_back(tx_bit_o);
      if (tx_done_o) begin
        done_seen = 1;
        done_busy = tx_busy_o;
        done_rs = dc_restart_o;
      end
    end
    if (done_seen) begin
      drive_cycle(1'b0, 1'b0, 1'b0);
      done_after = tx_done_o;
      bit_after = tx_bit_o;
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    logic [31:0] w;
    int d;
    #2 wb_rst_n = 1'b0;
    #3;
    n_checks++;
    if ({dc_restart_o, next_data_o, mir_tx_enabled_o, tx_bit_o, tx_busy_o, tx_done_o} !== 6'b0)
      $display("FAIL reset_outputs: got %b expected 000000",
               {dc_restart_o, next_data_o, mir_tx_enabled_o, tx_bit_o, tx_busy_o, tx_done_o});
    else n_pass++;
    @(negedge clk);
    wb_rst_n = 1'b1;
    @(negedge clk);
    w = $urandom;
    run_frame(w, 0, -1, -1, P_FLAGS * 8 + 10);
    n_checks++;
    if (pre_en !== 1'b1) $display("FAIL reset_in_data: mir_tx_enabled got %b expected 1", pre_en);
    else n_pass++;
    n_checks++;
    if (rst_outs !== 6'b0) $display("FAIL reset_mid_frame: outputs got %b expected 000000", rst_outs);
    else n_pass++;
    repeat (2) @(negedge clk);
    wb_rst_n = 1'b1;
    @(negedge clk);
    w = $urandom;
    model_frame(w);
    run_frame(w, 0, -1, -1, -1);
    n_checks++;
    if (rs_cnt !== 1) $display("FAIL reset_restart_pulse: dc_restart cycles got %0d expected 1", rs_cnt);
    else n_pass++;
    d = first_diff();
    n_checks++;
    if (obs_q.size() !== exp_q.size() || d !== -1)
      $display("FAIL reset_next_frame: len got %0d expected %0d first diff %0d", obs_q.size(), exp_q.size(), d);
    else n_pass++;
  endtask

  task automatic test_zero_word();
    int d;
    model_frame(32'h0000_0000);
    run_frame(32'h0000_0000, 0, -1, -1, -1);
    n_checks++;
    if (busy_start !== 1'b1) $display("FAIL zero_busy_rise: got %b expected 1", busy_start);
    else n_pass++;
    n_checks++;
    if (rs_cnt !== 1) $display("FAIL zero_restart: dc_restart cycles got %0d expected 1", rs_cnt);
    else n_pass++;
    n_checks++;
    if (nd_cnt !== 32) $display("FAIL zero_next_data: got %0d expected 32", nd_cnt);
    else n_pass++;
    n_checks++;
    if (obs_q.size() !== exp_q.size()) $display("FAIL zero_len: got %0d expected %0d", obs_q.size(), exp_q.size());
    else n_pass++;
    d = first_diff();
    n_checks++;
    if (d !== -1) $display("FAIL zero_bits: first diff at %0d got %b expected %b", d, obs_q[d], exp_q[d]);
    else n_pass++;
    n_checks++;
    if ({done_seen, done_busy, done_rs} !== 3'b100)
      $display("FAIL zero_done: done/busy/restart got %b expected 100", {done_seen, done_busy, done_rs});
    else n_pass++;
    n_checks++;
    if ({done_after, bit_after} !== 2'b00)
      $display("FAIL zero_done_width: done/bit after got %b expected 00", {done_after, bit_after});
    else n_pass++;
  endtask

  task automatic test_ones_word();
    int d, zeros;
    model_frame(32'hFFFF_FFFF);
    run_frame(32'hFFFF_FFFF, 0, -1, -1, -1);
    n_checks++;
    if (nd_cnt !== 32) $display("FAIL ones_next_data: got %0d expected 32", nd_cnt);
    else n_pass++;
    // 32 ones need a stuffed zero after each run of five: 38 data-region bits, 6 zeros
    zeros = 0;
    for (int i = P_FLAGS * 8; i < P_FLAGS * 8 + 38 && i < obs_q.size(); i++)
      if (obs_q[i] === 1'b0) zeros++;
    n_checks++;
    if (zeros !== 6) $display("FAIL ones_stuffed: zeros got %0d expected 6", zeros);
    else n_pass++;
    d = first_diff();
    n_checks++;
    if (obs_q.size() !== exp_q.size() || d !== -1)
      $display("FAIL ones_bits: len got %0d expected %0d first diff %0d", obs_q.size(), exp_q.size(), d);
    else n_pass++;
  endtask

  task automatic test_wait_data();
    logic [31:0] w;
    int d;
    w = $urandom;
    model_frame(w);
    run_frame(w, 50, -1, -1, -1);
    n_checks++;
    if (hold_bad !== 0) $display("FAIL wait_no_bits: tx_bit high cycles got %0d expected 0", hold_bad);
    else n_pass++;
    n_checks++;
    if (nd_hold !== 0) $display("FAIL wait_no_next: next_data got %0d expected 0", nd_hold);
    else n_pass++;
    d = first_diff();
    n_checks++;
    if (obs_q.size() !== exp_q.size() || d !== -1)
      $display("FAIL wait_bits: len got %0d expected %0d first diff %0d", obs_q.size(), exp_q.size(), d);
    else n_pass++;
  endtask

  task automatic test_start_ignored();
    logic [31:0] w;
    int d;
    w = $urandom;
    model_frame(w);
    run_frame(w, 0, P_FLAGS * 8 + 12, -1, -1);
    n_checks++;
    if (rs_cnt !== 1) $display("FAIL start_busy_restart: got %0d expected 1", rs_cnt);
    else n_pass++;
    d = first_diff();
    n_checks++;
    if (obs_q.size() !== exp_q.size() || d !== -1)
      $display("FAIL start_busy_bits: len got %0d expected %0d first diff %0d", obs_q.size(), exp_q.size(), d);
    else n_pass++;
  endtask

  task automatic test_back_to_back();
    logic [31:0] w;
    int d;
    for (int k = 0; k < 4; k++) begin
      w = $urandom;
      model_frame(w);
      run_frame(w, $urandom_range(0, 5), -1, -1, -1);
      d = first_diff();
      n_checks++;
      if (obs_q.size() !== exp_q.size() || d !== -1)
        $display("FAIL b2b_bits[%0d]: word %h len got %0d expected %0d first diff %0d",
                 k, w, obs_q.size(), exp_q.size(), d);
      else n_pass++;
      n_checks++;
      if (nd_cnt !== 32) $display("FAIL b2b_next_data[%0d]: got %0d expected 32", k, nd_cnt);
      else n_pass++;
    end
  endtask

`ifdef IRDA_MIR_ABORT_EN
  task automatic test_abort();
    int d, cut;
    cut = P_FLAGS * 8 + 32 + 4;
    model_frame(32'h0000_0000);
    while (exp_q.size() > cut) exp_q.pop_back();
    for (int i = 0; i < 8; i++) exp_q.push_back(1'b1);
    run_frame(32'h0000_0000, 0, -1, cut, -1);
    d = first_diff();
    n_checks++;
    if (obs_q.size() !== exp_q.size() || d !== -1)
      $display("FAIL abort_bits: len got %0d expected %0d first diff %0d", obs_q.size(), exp_q.size(), d);
    else n_pass++;
    n_checks++;
    if ({done_seen, done_rs} !== 2'b11)
      $display("FAIL abort_done_restart: done/restart got %b expected 11", {done_seen, done_rs});
    else n_pass++;
  endtask
`endif

  initial begin
    test_reset();
    test_zero_word();
    test_ones_word();
    test_wait_data();
    test_start_ignored();
    test_back_to_back();
`ifdef IRDA_MIR_ABORT_EN
    test_abort();
`endif
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
